// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encoding for the UART blocks
//
// Purpose: oversampling rate, default baud divider and receiver state encoding.
// Ports:   none (package).
package uart_pkg;

   localparam int OS_RATE         = 16;   // oversample ticks per bit
   localparam int DEFAULT_CLK_DIV = 54;   // 100 MHz / (115200 * 16)

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick generator
//
// Purpose: divides clk by CLK_DIV and emits a one-clk tick on each wrap.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous reset, active-high (counter cleared)
//   tick out  1 for one clk every CLK_DIV clks
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CW'(CLK_DIV - 1));

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver with 16x oversampling
//
// Purpose: turns the raw rx pin into bytes. Optional even-parity checking is
// enabled by defining UART_RX_PARITY_EN; otherwise parity_err is tied to 0.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   rx          in   asynchronous serial line, idle high
//   rx_data     out  last correctly received byte, held until the next good frame
//   rx_done     out  one-clk pulse: rx_data has just been updated
//   frame_err   out  one-clk pulse: stop bit sampled low, byte discarded
//   parity_err  out  one-clk pulse: parity mismatch, byte discarded
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV,
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rx,
   output logic [DBIT-1:0] rx_data,
   output logic            rx_done,
   output logic            frame_err,
   output logic            parity_err
);

   localparam int         NW     = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [3:0] S_MID  = 4'(OS_RATE / 2 - 1);
   localparam logic [3:0] S_LAST = 4'(OS_RATE - 1);
   localparam logic [3:0] S_STOP = 4'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

   logic            tick;
   logic            rx_meta_q, rx_sync_q;
   uart_state_e     state_q, state_d;
   logic [3:0]      s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] sh_q, sh_d;
   logic [DBIT-1:0] data_q, data_d;
   logic            done_q, done_d;
   logic            ferr_q, ferr_d;
   logic            discard;

`ifdef UART_RX_PARITY_EN
   logic perr_q, perr_d;
   logic bad_q, bad_d;     // parity failed: STOP is still walked but reports nothing
   assign discard    = bad_q;
   assign parity_err = perr_q;
`else
   assign discard    = 1'b0;
   assign parity_err = 1'b0;
`endif

   uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      sh_d    = sh_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
      bad_d   = bad_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!rx_sync_q) begin
               state_d = ST_START;
               s_d     = '0;
            end
         end
         ST_START: begin
            if (tick) begin
               if (s_q == S_MID) begin
                  // Line back high at mid start bit: glitch, not a frame.
                  if (!rx_sync_q) begin
                     state_d = ST_DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (s_q == S_LAST) begin
                  s_d  = '0;
                  sh_d = {rx_sync_q, sh_q[DBIT-1:1]};   // LSB first
                  if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               if (s_q == S_LAST) begin
                  s_d     = '0;
                  state_d = ST_STOP;
                  if (rx_sync_q != ^sh_q) begin
                     perr_d = 1'b1;
                     bad_d  = 1'b1;
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               if (s_q == S_STOP) begin
                  state_d = ST_IDLE;
                  s_d     = '0;
`ifdef UART_RX_PARITY_EN
                  bad_d   = 1'b0;
`endif
                  if (!discard) begin
                     if (rx_sync_q) begin
                        data_d = sh_q;
                        done_d = 1'b1;
                     end else begin
                        ferr_d = 1'b1;
                     end
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         state_q   <= ST_IDLE;
         s_q       <= '0;
         n_q       <= '0;
         sh_q      <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q    <= 1'b0;
         bad_q     <= 1'b0;
`endif
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         state_q   <= state_d;
         s_q       <= s_d;
         n_q       <= n_d;
         sh_q      <= sh_d;
         data_q    <= data_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
         perr_q    <= perr_d;
         bad_q     <= bad_d;
`endif
      end
   end

   assign rx_data   = data_q;
   assign rx_done   = done_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - scoreboard bench for uart_rx_byte
module tb_uart_rx_byte;

   // Divider scaled down for run time; the bit period keeps a small baud
   // mismatch against the receiver, like 115200 against 100 MHz / 54 / 16.
   localparam int CLK_DIV = 10;
   localparam int BIT_NS  = 1606;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] rx_data;
   logic       rx_done, frame_err, parity_err;

   always #5 clk = ~clk;

   uart_rx_byte #(.CLK_DIV(CLK_DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_done    (rx_done),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   // kind: 0 = rx_done, 1 = frame_err, 2 = parity_err
   typedef struct {
      int         kind;
      logic [7:0] data;
   } exp_t;

   exp_t       sb_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] last_good = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Reference: a frame is discarded on bad parity first, then on a low stop bit.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
      exp_t e;
      bit   pbit;
      pbit = (^b) ^ !par_ok;
      if (PAR && !par_ok)  e = '{2, last_good};
      else if (!stop_ok)   e = '{1, last_good};
      else begin
         e = '{0, b};
         last_good = b;
      end
      sb_q.push_back(e);
      rx = 1'b0;
      #BIT_NS;
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #BIT_NS;
      end
      if (PAR) begin
         rx = pbit;
         #BIT_NS;
      end
      if (stop_ok) begin
         rx = 1'b1;
         #BIT_NS;
      end else begin
         // Low stop bit cut short so the line is high again before a new start is qualified.
         rx = 1'b0;
         #1004;
         rx = 1'b1;
         #602;
      end
   endtask

   task automatic idle_bits(input int nbits);
      rx = 1'b1;
      for (int i = 0; i < nbits; i++) #BIT_NS;
   endtask

   task automatic drain();
      int cnt = 0;
      while (sb_q.size() != 0 && cnt < 4000) begin
         @(negedge clk);
         cnt++;
      end
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: %0d outstanding, required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   // Monitor: every output pulse pops one expectation.
   exp_t mon_e;
   int   mon_kind;
   always @(negedge clk) begin
      if ((int'(rx_done) + int'(frame_err) + int'(parity_err)) > 1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL pulse_exclusive: done=%0b ferr=%0b perr=%0b required at most one",
                  rx_done, frame_err, parity_err);
      end else if (rx_done || frame_err || parity_err) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: done=%0b ferr=%0b perr=%0b data=%0h required none",
                     rx_done, frame_err, parity_err, rx_data);
         end else begin
            mon_e    = sb_q.pop_front();
            mon_kind = rx_done ? 0 : (frame_err ? 1 : 2);
            check("pulse_kind", mon_kind, mon_e.kind);
            check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b2b [4];
      logic [7:0] rb;
      bit         st_ok, p_ok;
      b2b = '{8'h01, 8'h02, 8'h03, 8'h04};

      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      check("reset_pulses", {29'd0, rx_done, frame_err, parity_err}, 32'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Single good byte
      send_frame(8'hA5, 1'b1, 1'b1);
      drain();

      // Back-to-back bytes, no idle gap
      @(negedge clk);
      foreach (b2b[i]) send_frame(b2b[i], 1'b1, 1'b1);
      drain();

      // Short low glitch: no pulse, then a clean byte
      idle_bits(1);
      @(negedge clk);
      rx = 1'b0;
      #(4 * CLK_DIV * 10);
      rx = 1'b1;
      #(2 * BIT_NS);
      @(negedge clk);
      send_frame(8'h7E, 1'b1, 1'b1);
      drain();

      // Framing error after a good byte: rx_data holds 0x11
      @(negedge clk);
      send_frame(8'h11, 1'b1, 1'b1);
      send_frame(8'h3C, 1'b0, 1'b1);
      idle_bits(1);
      drain();

      // Reset during data bit 3 of 0xFF, then a clean byte
      @(negedge clk);
      rx = 1'b0;
      #BIT_NS;
      rx = 1'b1;
      #(3 * BIT_NS + 800);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_good = 8'h00;
      check("midframe_rst_rx_data", {24'd0, rx_data}, 32'd0);
      check("midframe_rst_pulses", {29'd0, rx_done, frame_err, parity_err}, 32'd0);
      #(8 * BIT_NS);
      @(negedge clk);
      send_frame(8'h5A, 1'b1, 1'b1);
      drain();

`ifdef UART_RX_PARITY_EN
      // Wrong parity then correct parity
      @(negedge clk);
      send_frame(8'h0F, 1'b1, 1'b0);
      idle_bits(1);
      send_frame(8'h0F, 1'b1, 1'b1);
      drain();
`endif

      // Randomized frames against the reference model
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         rb    = 8'($urandom);
         st_ok = ($urandom_range(0, 4) != 0);
         p_ok  = PAR ? ($urandom_range(0, 3) != 0) : 1'b1;
         send_frame(rb, st_ok, p_ok);
         if (!st_ok) idle_bits(1 + $urandom_range(0, 1));
         else        idle_bits($urandom_range(0, 2));
      end
      drain();

      repeat (50) @(negedge clk);
      check("final_outstanding", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
